// File: rtl/uart_tx_sched.sv
// uart_tx_sched: byte FIFO feeding an 8N1 serial transmitter.
// The CPU-side write port pushes bytes into a small circular FIFO; the
// transmit FSM pops one byte per frame and shifts it out LSB first on TXD.
//
// Handshake (write port): a transfer happens on a rising CLK edge where
// wr_valid && wr_ready are both high. wr_ready depends only on the registered
// FIFO level, so a pop in the same cycle never opens a slot early. The
// producer holds wr_data/wr_valid stable until the transfer happens.
module uart_tx_sched #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          TXD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    fsm_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);

  // Reject parameter values the pointer and counter arithmetic cannot handle.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [7:0]    shift_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic          txd_q;

  logic          push;
  logic          pop;
  logic          fifo_has_data;
  logic          bit_done;
  logic [7:0]    head;

  // Handshake and pop decisions all come from registered state.
  always_comb begin
    wr_ready      = (level_q != LVL_FULL);
    push          = wr_valid && wr_ready;
    fifo_has_data = (level_q != '0);
    bit_done      = (cnt_q == CNT_MAX);
    head          = mem[rd_ptr_q];
    pop           = fifo_has_data &&
                    ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  end

  // Byte storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit.
  // TXD is updated together with the state so the line is always registered.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          cnt_q <= '0;
          if (pop) begin
            shift_q   <= head;
            bit_idx_q <= '0;
            txd_q     <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (pop) begin
              // Chain straight into the next frame with no idle gap.
              shift_q   <= head;
              bit_idx_q <= '0;
              txd_q     <= 1'b0;
              state_q   <= START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          txd_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded from registers only.
  always_comb begin
    TXD        = txd_q;
    fifo_level = level_q;
    fsm_state  = state_q;
    busy       = (state_q != IDLE) || (level_q != '0);
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed stimulus for uart_tx_sched with a serial-line
// monitor that decodes TXD frames and checks them against an expected queue.
module tb_uart_tx_sched;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       TXD;
  logic       busy;
  logic [2:0] fifo_level;
  logic [1:0] fsm_state;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_tx_sched #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .TXD        (TXD),
    .busy       (busy),
    .fifo_level (fifo_level),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_rx     = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         mon_busy  = 1'b0;
  bit         mon_abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor: decode 8N1 frames on TXD ----------------
  initial begin : monitor
    logic [7:0] b;
    logic       start_ok;
    logic [7:0] want;
    forever begin
      @(negedge CLK);
      if (RESET === 1'b1 && TXD === 1'b0) begin
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        @(negedge CLK);
        start_ok = (TXD === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b[i] = TXD;
        end
        repeat (CPB) @(negedge CLK);
        if (mon_abort) begin
          mon_abort = 1'b0;
        end else begin
          check("frame_start_bit", start_ok, 1);
          check("frame_stop_bit", TXD, 1);
          check("frame_expected_present", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("frame_data", b, want);
          end
          n_rx++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offers a byte from a negedge and holds it until accepted; returns the
  // number of the rising edge on which the transfer happened.
  task automatic send(input logic [7:0] b, output int acc);
    int n;
    n   = 0;
    acc = -1;
    wr_data  = b;
    wr_valid = 1'b1;
    while (acc < 0 && n < 400) begin
      if (wr_ready === 1'b1) acc = cyc + 1;
      @(negedge CLK);
      n++;
    end
    check("send_accepted", acc >= 0, 1);
    if (acc >= 0) exp_q.push_back(b);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || mon_busy) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("drain_to_idle", (busy === 1'b0) && !mon_busy, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int         k;
    int         k2;
    int         acc[6];
    int         off;
    int         seg;
    int         highs;
    logic [7:0] v;
    logic       exp_bit;

    RESET    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_txd", TXD, 1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_state", fsm_state, 0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // Single byte: exact waveform and timing.
    v = 8'h55;
    send(v, k);
    check("t1_level_after_push", fifo_level, 1);
    check("t1_busy_after_push", busy, 1);
    check("t1_txd_idle_at_k", TXD, 1);
    for (int e = k + 1; e <= k + 41; e++) begin
      @(negedge CLK);
      off = e - k - 1;
      seg = off / CPB;
      if (seg == 0)      exp_bit = 1'b0;
      else if (seg <= 8) exp_bit = v[seg-1];
      else               exp_bit = 1'b1;
      check("t1_txd_wave", TXD, exp_bit);
      if (e == k + 1)  check("t1_level_popped", fifo_level, 0);
      if (e == k + 40) check("t1_busy_in_stop", busy, 1);
      if (e == k + 41) check("t1_busy_fall", busy, 0);
    end
    wait_idle(100);

    // Back-to-back: second start exactly one frame after the first.
    start_q.delete();
    send(8'hA3, k);
    send(8'h0F, k2);
    check("t2_consecutive_accept", k2 - k, 1);
    wait_idle(200);
    check("t2_frames_seen", start_q.size(), 2);
    check("t2_start_spacing", start_q[1] - start_q[0], 40);

    // Backpressure and full-plus-pop in the same cycle.
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), acc[i]);
    check("t3_five_consecutive", acc[4] - acc[0], 4);
    check("t3_full_ready_low", wr_ready, 0);
    check("t3_full_level", fifo_level, 4);
    send(8'h15, acc[5]);
    check("t3_accept_after_pop", acc[5] - acc[0], 42);
    check("t3_level_refilled", fifo_level, 4);
    check("t3_ready_low_again", wr_ready, 0);
    wait_idle(400);

    // Pointer wrap: 12 bytes through a depth-4 FIFO.
    for (int i = 0; i < 12; i++) send(8'(i), k2);
    wait_idle(800);

    // Reset in the middle of data bit 3 with two bytes queued.
    send(8'hC6, k);
    send(8'h81, k2);
    send(8'h7E, k2);
    while (cyc < k + 18) @(negedge CLK);
    check("t5_state_data", fsm_state, 2);
    check("t5_level_two", fifo_level, 2);
    check("t5_txd_bit3", TXD, 0);
    #2;
    RESET = 1'b0;
    mon_abort = mon_busy;
    exp_q.delete();
    #1;
    check("t5_async_txd", TXD, 1);
    check("t5_async_level", fifo_level, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_ready", wr_ready, 1);
    check("t5_async_state", fsm_state, 0);
    @(negedge CLK);
    RESET = 1'b1;
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (TXD === 1'b1 && busy === 1'b0) highs++;
    end
    check("t5_line_stays_idle", highs, 50);
    send(8'h3C, k);
    wait_idle(100);

    check("total_frames_decoded", n_rx, 22);
    check("expected_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
